imem_fetch_ctrl: RTL and testbench

//   Fetch sequencer for the 8-bit-addressed, combinational instruction ROM (A -> RD, same cycle).

---
 rtl/imem_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and fetch sequencer for a combinational instruction ROM.
// Presents the PC as the ROM address, captures the returned word into a
// one-entry output register with a valid/ready handshake, follows redirects
// and parks in HALT when the ROM returns an all-zero (unmapped) word.
module imem_fetch_ctrl #(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter bit                HALT_ON_ZERO = 1'b1,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  issue_cnt
);

    // Word alignment mask and sequential PC increment.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic               r_out_valid;
    logic               w_out_valid_next;
    logic [31:0]        r_out_instr;
    logic [31:0]        w_out_instr_next;
    logic [ADDR_W-1:0]  r_out_pc;
    logic [ADDR_W-1:0]  w_out_pc_next;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   w_issue_cnt_next;

    logic [ADDR_W-1:0]  w_redirect_target;
    logic               w_slot_free;
    logic               w_zero_word;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Redirect targets are forced onto a word boundary.
    assign w_redirect_target = redirect_pc & ALIGN_MASK;
    // The output register can take a new word if empty or being drained now.
    assign w_slot_free       = !r_out_valid || out_ready;
    assign w_zero_word       = HALT_ON_ZERO && (imem_rdata == 32'h0);
    // Saturating issue counter increment.
    assign w_cnt_inc         = (&r_issue_cnt) ? r_issue_cnt : r_issue_cnt + CNT_W'(1);

    // State and datapath registers; reset dominates everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= PC_INIT;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0;
            r_out_pc    <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_out_valid <= w_out_valid_next;
            r_out_instr <= w_out_instr_next;
            r_out_pc    <= w_out_pc_next;
            r_issue_cnt <= w_issue_cnt_next;
        end
    end

    // Next-state and datapath update; default is hold, with a consumed word dropping valid.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_out_valid_next = r_out_valid && !out_ready;
        w_out_instr_next = r_out_instr;
        w_out_pc_next    = r_out_pc;
        w_issue_cnt_next = r_issue_cnt;

        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_pc_next = w_redirect_target;
                end else if (start) begin
                    w_state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                if (redirect) begin
                    // Flush: any handshake this cycle still completes, nothing new is captured.
                    w_pc_next        = w_redirect_target;
                    w_out_valid_next = 1'b0;
                end else if (w_slot_free) begin
                    if (w_zero_word) begin
                        // PC stays on the zero word so the halt address stays visible.
                        w_out_valid_next = 1'b0;
                        w_state_next     = S_HALT;
                    end else begin
                        w_out_instr_next = imem_rdata;
                        w_out_pc_next    = r_pc;
                        w_out_valid_next = 1'b1;
                        w_pc_next        = r_pc + PC_STEP;
                        w_issue_cnt_next = w_cnt_inc;
                    end
                end
            end

            S_HALT: begin
                if (redirect) begin
                    w_pc_next        = w_redirect_target;
                    w_out_valid_next = 1'b0;
                    w_state_next     = S_FETCH;
                end
            end

            default: begin
                w_state_next     = S_IDLE;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign halted    = (r_state == S_HALT);
    assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed sequences against a 6-word ROM image,
// with a queue-based scoreboard checking every accepted output word.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        out_ready;

    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;
    logic [15:0] issue_cnt;

    // Second instance with a 3-bit counter to reach saturation quickly.
    logic [7:0]  s_imem_addr;
    logic [31:0] s_imem_rdata;
    logic        s_out_valid;
    logic [31:0] s_out_instr;
    logic [7:0]  s_out_pc;
    logic        s_halted;
    logic [2:0]  s_issue_cnt;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] rom_rd(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h00100193;
            8'h04:   return 32'h0ff00083;
            8'h08:   return 32'h0011f133;
            8'h0C:   return 32'h003122b3;
            8'h10:   return 32'h0e500fa3;
            8'h14:   return 32'hfe0008e3;
            default: return 32'h0;
        endcase
    endfunction

    assign imem_rdata   = rom_rd(imem_addr);
    assign s_imem_rdata = rom_rd(s_imem_addr);

    imem_fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_ON_ZERO(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .halted(halted), .issue_cnt(issue_cnt)
    );

    imem_fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_ON_ZERO(1'b1), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_instr(s_out_instr), .out_pc(s_out_pc),
        .halted(s_halted), .issue_cnt(s_issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push(input logic [7:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = rom_rd(pc);
        exp_q.push_back(e);
    endtask

    task automatic wait_halt(input int budget);
        int k;
        k = 0;
        while (!halted && k < budget) begin
            tick();
            k++;
        end
        if (!halted) begin
            n_cmp++;
            n_err++;
            $display("FAIL halt_timeout: got halted=%0b after %0d cycles required 1", halted, budget);
        end
    endtask

    // Monitor: every word accepted at the coming edge is checked against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got pc=%h instr=%h required no transfer", out_pc, out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    n_err++;
                    $display("FAIL xfer: got pc=%h instr=%h required pc=%h instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end else begin
                    $display("xfer pc=%h instr=%h", out_pc, out_instr);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", {24'd0, out_pc}, 32'h0);
        chk("rst_imem_addr", {24'd0, imem_addr}, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_issue_cnt", {16'd0, issue_cnt}, 32'd0);

        // Straight-line run to the zero word.
        for (int i = 0; i < 6; i++) push(8'(i * 4));
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_start_n1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_start_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_first_pc", {24'd0, out_pc}, 32'h00);
        wait_halt(20);
        chk("t1_halted", {31'd0, halted}, 32'd1);
        chk("t1_issue_cnt", {16'd0, issue_cnt}, 32'd6);
        chk("t1_sat_cnt", {29'd0, s_issue_cnt}, 32'd6);
        chk("t1_halt_addr", {24'd0, imem_addr}, 32'h18);
        chk("t1_halt_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) tick();
        chk("t1_halt_hold_addr", {24'd0, imem_addr}, 32'h18);

        // Leave HALT by redirect; stall; redirect with handshake; misaligned redirect.
        for (int i = 0; i < 6; i++) push(8'(i * 4));
        push(8'h04); push(8'h08); push(8'h0C); push(8'h10); push(8'h14);
        redirect = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect = 1'b0;
        chk("t5_halted_drop", {31'd0, halted}, 32'd0);
        chk("t5_valid_after_redir", {31'd0, out_valid}, 32'd0);
        chk("t5_addr_after_redir", {24'd0, imem_addr}, 32'h00);
        tick();
        chk("t5_first_instr", out_instr, 32'h00100193);
        chk("t5_cnt_continues", {16'd0, issue_cnt}, 32'd7);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall_instr", out_instr, 32'h0ff00083);
            chk("t2_stall_pc", {24'd0, out_pc}, 32'h04);
            chk("t2_stall_addr", {24'd0, imem_addr}, 32'h08);
            chk("t2_stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("t2_next_instr", out_instr, 32'h0011f133);
        chk("t2_next_pc", {24'd0, out_pc}, 32'h08);
        repeat (3) tick();
        chk("t3_at_pc14", {24'd0, out_pc}, 32'h14);
        redirect = 1'b1; redirect_pc = 8'h04;
        tick();
        redirect = 1'b0;
        chk("t3_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_flush_addr", {24'd0, imem_addr}, 32'h04);
        tick();
        chk("t3_refetch_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_refetch_pc", {24'd0, out_pc}, 32'h04);
        chk("t3_refetch_instr", out_instr, 32'h0ff00083);
        redirect = 1'b1; redirect_pc = 8'h0A;
        tick();
        redirect = 1'b0;
        chk("t4_align_addr", {24'd0, imem_addr}, 32'h08);
        chk("t4_flush_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t4_next_instr", out_instr, 32'h0011f133);
        chk("t4_next_pc", {24'd0, out_pc}, 32'h08);
        wait_halt(20);
        chk("t5_issue_cnt_total", {16'd0, issue_cnt}, 32'd17);
        chk("sat_cnt_saturated", {29'd0, s_issue_cnt}, 32'd7);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        // Reset during an open, stalled handshake.
        redirect = 1'b1; redirect_pc = 8'h00; out_ready = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_pre_addr", {24'd0, imem_addr}, 32'h04);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_addr", {24'd0, imem_addr}, 32'h00);
        chk("t6_rst_halted", {31'd0, halted}, 32'd0);
        chk("t6_rst_cnt", {16'd0, issue_cnt}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle_valid", {31'd0, out_valid}, 32'd0);
            chk("t6_idle_addr", {24'd0, imem_addr}, 32'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
